motor_start_scheduler: RTL

MOTOR_START_SCHEDULER -- requirements
Module: motor_start_scheduler

---
 rtl/motor_start_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_start_scheduler.sv
// motor_start_scheduler
// Round-robin arbiter that lends one shared start-up monitor (x/y sensors,
// f/g outputs) to NCH motor channels, one start-up session at a time.
// A session issues a start pulse and waits for the x pattern 1,0,1. It then
// checks y for up to two cycles with the motor run-enabled. It ends with a
// one-cycle done strobe carrying the pass/fail result. Passing channels get
// a sticky run flag.
//
// Build option:
//   MOTOR_SCHED_TIMEOUT_EN  - when defined, a cycle counter aborts x-sequence
//                             detection after TIMEOUT cycles with pass=0.
//                             When undefined, detection waits indefinitely.
module motor_start_scheduler #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           x,
  input  logic           y,
  output logic [NCH-1:0] grant,
  output logic           f,
  output logic           g,
  output logic           done,
  output logic           pass,
  output logic [NCH-1:0] run
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PULSE = 3'd1;
  localparam logic [2:0] ST_S0    = 3'd2;
  localparam logic [2:0] ST_S1    = 3'd3;
  localparam logic [2:0] ST_S10   = 3'd4;
  localparam logic [2:0] ST_G1    = 3'd5;
  localparam logic [2:0] ST_G2    = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  logic [2:0]     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gidx_q, gidx_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic           pass_q, pass_d;
  logic [NCH-1:0] run_q, run_d;
  logic [NCH-1:0] run_clr, run_set;

  logic [PW-1:0]  cand_idx [NCH];
  logic [NCH-1:0] pick_onehot;
  logic [PW-1:0]  pick_idx;
  logic           pick_found;
  logic [PW-1:0]  ptr_after;
  logic           expired;

  // Candidate channel order: the pointer first, then upward with wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cand
      assign cand_idx[gi]    = PW'((int'(ptr_q) + gi) % NCH);
      assign pick_onehot[gi] = pick_found && (pick_idx == PW'(gi));
      assign run_d[gi]       = run_set[gi] | (run_q[gi] & ~run_clr[gi]);
    end
  endgenerate

  // Select the requester with the smallest offset from the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[cand_idx[i]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  // The channel after the granted one becomes the next search start.
  assign ptr_after = (gidx_q == PW'(NCH - 1)) ? '0 : gidx_q + 1'b1;

`ifdef MOTOR_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       in_detect;

  assign in_detect = (state_q == ST_S0) || (state_q == ST_S1) || (state_q == ST_S10);
  assign expired   = in_detect && (cnt_q == 8'(TIMEOUT - 1));

  // Detection cycle counter: restarts as S0 is entered, counts while detecting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_PULSE) begin
      cnt_d = '0;
    end else if (in_detect) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // Session sequencing, arbitration and result capture.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    pass_d  = pass_q;
    run_clr = '0;
    run_set = '0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d = ST_PULSE;
          gidx_d  = pick_idx;
          grant_d = pick_onehot;
          pass_d  = 1'b0;
          run_clr = pick_onehot;
        end
      end
      ST_PULSE: state_d = ST_S0;
      ST_S0: begin
        if (expired) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end else if (x) begin
          state_d = ST_S1;
        end
      end
      ST_S1: begin
        if (expired) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end else if (!x) begin
          state_d = ST_S10;
        end
      end
      ST_S10: begin
        // A completed pattern beats a timeout landing on the same cycle.
        if (x) begin
          state_d = ST_G1;
        end else if (expired) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_S0;
        end
      end
      ST_G1: begin
        if (y) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_G2;
        end
      end
      ST_G2: begin
        pass_d  = y;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (pass_q) begin
          run_set = grant_q;
        end
        ptr_d   = ptr_after;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      pass_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      pass_q  <= pass_d;
      run_q   <= run_d;
    end
  end

  // In IDLE the pending pick is shown so a grant leads f by one cycle.
  assign grant = (state_q == ST_IDLE) ? pick_onehot : grant_q;
  assign f     = (state_q == ST_PULSE);
  assign g     = (state_q == ST_G1) || (state_q == ST_G2);
  assign done  = (state_q == ST_DONE);
  assign pass  = (state_q == ST_DONE) && pass_q;
  assign run   = run_q;

endmodule
